// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-length output levels, with a
// saturating pending-pulse queue, optional retrigger and a guaranteed low gap.
module pulse_stretcher #(
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 2,
  parameter int QDEPTH   = 3,
  parameter int CNT_W    = 26,
  localparam int QW      = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_pulse,
  input  logic          retrig_en,
  input  logic          clr,
  output logic          out_level,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [QW-1:0] pend_cnt
);

  // state | meaning
  // IDLE  | no output active, queue empty
  // HOLD  | out_level high, cnt counts remaining high cycles
  // GAP   | forced low gap, cnt counts remaining low cycles
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [QW-1:0]    PEND_MAX = QW'(QDEPTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [QW-1:0]    pend_q, pend_d;
  logic             done_d, ovf_d, queue_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      out_level <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      out_level <= (state_d == HOLD);
      busy      <= (state_d != IDLE);
      done      <= done_d;
      overflow  <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    ovf_d     = 1'b0;
    queue_req = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_pulse) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end
        end
        HOLD: begin
          if (in_pulse && retrig_en) begin
            cnt_d = HOLD_LD;
          end else begin
            queue_req = in_pulse;
            if (cnt_q <= CNT_ONE) begin
              state_d = GAP;
              cnt_d   = GAP_LD;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        GAP: begin
          if (cnt_q <= CNT_ONE) begin
            // A pulse on the final gap edge either cancels the dequeue or starts directly
            if (pend_q != '0) begin
              state_d = HOLD;
              cnt_d   = HOLD_LD;
              if (!in_pulse) pend_d = pend_q - QW'(1);
            end else if (in_pulse) begin
              state_d = HOLD;
              cnt_d   = HOLD_LD;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d     = cnt_q - CNT_ONE;
            queue_req = in_pulse;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      if (queue_req) begin
        if (pend_q >= PEND_MAX) ovf_d = 1'b1;
        else pend_d = pend_q + QW'(1);
      end
    end
  end

  assign pend_cnt = pend_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed scenarios with literal expected schedules, then randomized traffic
// checked against a countdown model of the stretcher.
module tb_pulse_stretcher;
  localparam int H = 4;
  localparam int G = 2;
  localparam int Q = 3;

  logic       clk, rst_n, in_pulse, retrig_en, clr;
  logic       out_level, busy, done, overflow;
  logic [1:0] pend_cnt;

  int total = 0;
  int bad   = 0;

  int m_hold, m_gap, m_pend;
  bit m_done, m_ovf;

  pulse_stretcher #(.HOLD_CYC(H), .GAP_CYC(G), .QDEPTH(Q), .CNT_W(26)) dut (
    .clk(clk), .rst_n(rst_n), .in_pulse(in_pulse), .retrig_en(retrig_en), .clr(clr),
    .out_level(out_level), .busy(busy), .done(done), .overflow(overflow), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Reference: hold time left, gap time left, pending count as plain integers.
  task automatic model_step(input bit p, input bit rt, input bit c);
    bit enqueue;
    enqueue = 0;
    m_done  = 0;
    m_ovf   = 0;
    if (c) begin
      m_hold = 0; m_gap = 0; m_pend = 0;
    end else if (m_hold > 0) begin
      if (p && rt) m_hold = H;
      else begin
        enqueue = p;
        if (m_hold == 1) begin m_hold = 0; m_gap = G; m_done = 1; end
        else m_hold = m_hold - 1;
      end
    end else if (m_gap > 0) begin
      if (m_gap == 1) begin
        m_gap = 0;
        if (m_pend > 0) begin m_hold = H; m_pend = m_pend - 1 + (p ? 1 : 0); end
        else if (p) m_hold = H;
      end else begin
        m_gap   = m_gap - 1;
        enqueue = p;
      end
    end else if (p) m_hold = H;
    if (enqueue) begin
      if (m_pend < Q) m_pend++;
      else m_ovf = 1;
    end
  endtask

  task automatic test_reset();
    total++;
    if ({out_level, busy, done, overflow, pend_cnt} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=000000", {out_level, busy, done, overflow, pend_cnt});
    end
  endtask

  task automatic test_single();
    retrig_en = 0; clr = 0;
    for (int e = 0; e < 8; e++) begin
      in_pulse = (e == 0);
      edge_step();
      total++;
      if ({out_level, done, busy} !== {e <= 3, e == 4, e <= 5}) begin
        bad++;
        $display("FAIL single cyc=%0d got(out,done,busy)=%b%b%b want=%b%b%b",
                 e, out_level, done, busy, e <= 3, e == 4, e <= 5);
      end
    end
    in_pulse = 0;
  endtask

  task automatic test_queue();
    bit want_out;
    retrig_en = 0; clr = 0;
    for (int e = 0; e < 20; e++) begin
      in_pulse = (e <= 2);
      edge_step();
      want_out = (e <= 3) || (e >= 6 && e <= 9) || (e >= 12 && e <= 15);
      total++;
      if ({out_level, done, busy} !== {want_out, e == 4 || e == 10 || e == 16, e < 18}) begin
        bad++;
        $display("FAIL queue cyc=%0d got(out,done,busy)=%b%b%b want=%b%b%b", e, out_level, done,
                 busy, want_out, e == 4 || e == 10 || e == 16, e < 18);
      end
      if (e == 2) begin
        total++;
        if (pend_cnt !== 2'd2) begin
          bad++;
          $display("FAIL queue_pend got=%0d want=2", pend_cnt);
        end
      end
    end
    in_pulse = 0;
  endtask

  task automatic test_retrig();
    retrig_en = 1; clr = 0;
    for (int e = 0; e < 9; e++) begin
      in_pulse = (e == 0 || e == 2);
      edge_step();
      total++;
      if ({out_level, done, pend_cnt} !== {e <= 5, e == 6, 2'd0}) begin
        bad++;
        $display("FAIL retrig cyc=%0d got(out,done,pend)=%b%b%0d want=%b%b0",
                 e, out_level, done, pend_cnt, e <= 5, e == 6);
      end
    end
    in_pulse = 0; retrig_en = 0;
  endtask

  task automatic test_overflow();
    int  rises;
    bit  prev;
    rises = 0; prev = 0;
    retrig_en = 0; clr = 0;
    for (int e = 0; e < 28; e++) begin
      in_pulse = (e <= 4);
      edge_step();
      if (out_level && !prev) rises++;
      prev = out_level;
      total++;
      if (overflow !== (e == 4)) begin
        bad++;
        $display("FAIL overflow_strobe cyc=%0d got=%b want=%b", e, overflow, e == 4);
      end
      if (e == 3) begin
        total++;
        if (pend_cnt !== 2'd3) begin
          bad++;
          $display("FAIL overflow_pend got=%0d want=3", pend_cnt);
        end
      end
    end
    in_pulse = 0;
    total++;
    if (rises != 4 || busy !== 1'b0) begin
      bad++;
      $display("FAIL overflow_outputs got rises=%0d busy=%b want rises=4 busy=0", rises, busy);
    end
  endtask

  task automatic test_clr();
    retrig_en = 0;
    for (int e = 0; e < 12; e++) begin
      in_pulse = (e <= 2);
      clr      = (e == 2);
      edge_step();
      if (e >= 2) begin
        total++;
        if ({out_level, busy, done, overflow, pend_cnt} !== 6'b0) begin
          bad++;
          $display("FAIL clr cyc=%0d got=%b want=000000", e,
                   {out_level, busy, done, overflow, pend_cnt});
        end
      end
    end
    in_pulse = 0; clr = 0;
  endtask

  task automatic test_async_reset();
    retrig_en = 0; clr = 0;
    for (int e = 0; e < 3; e++) begin
      in_pulse = (e == 0);
      edge_step();
    end
    in_pulse = 0;
    #2 rst_n = 0;
    #1;
    total++;
    if ({out_level, busy, done, overflow, pend_cnt} !== 6'b0) begin
      bad++;
      $display("FAIL async_reset got=%b want=000000", {out_level, busy, done, overflow, pend_cnt});
    end
    @(negedge clk);
    rst_n = 1;
    test_single();
  endtask

  task automatic test_random();
    bit p, rt, c;
    clr = 1; in_pulse = 0; retrig_en = 0;
    edge_step();
    model_step(0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      p  = ($urandom_range(0, 99) < 45);
      rt = ($urandom_range(0, 99) < 30);
      c  = ($urandom_range(0, 99) < 2);
      in_pulse = p; retrig_en = rt; clr = c;
      edge_step();
      model_step(p, rt, c);
      total++;
      if ({out_level, busy, done, overflow, pend_cnt} !==
          {m_hold > 0, (m_hold > 0) || (m_gap > 0), m_done, m_ovf, 2'(m_pend)}) begin
        bad++;
        $display("FAIL random i=%0d got(out,busy,done,ovf,pend)=%b%b%b%b%0d want=%b%b%b%b%0d", i,
                 out_level, busy, done, overflow, pend_cnt, m_hold > 0,
                 (m_hold > 0) || (m_gap > 0), m_done, m_ovf, m_pend);
      end
    end
    in_pulse = 0; retrig_en = 0; clr = 0;
  endtask

  initial begin
    rst_n = 0; in_pulse = 0; retrig_en = 0; clr = 0;
    #2;
    test_reset();
    #10 rst_n = 1;
    test_single();
    test_queue();
    test_retrig();
    test_overflow();
    test_clr();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
